// File: rtl/instruction_ram_loader.sv
// Copies `length` source words into instruction RAM from dest_base; optional checksum port via INSTRUCTION_RAM_LOADER_CHECKSUM_EN.
// Latency: 3 cycles per word when src_read_valid arrives in the first WAIT cycle; done follows the last write by one cycle.
// Backpressure: one read outstanding; waits up to TIMEOUT_CYCLES for src_read_valid, then aborts with error.
module instruction_ram_loader #(
    parameter int DATA_WIDTH     = 32,
    parameter int I_ADDR_WIDTH   = 10,
    parameter int SRC_ADDR_WIDTH = 16,
    parameter int I_RAM_DEPTH    = 83,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [SRC_ADDR_WIDTH-1:0] src_base,
    input  logic [I_ADDR_WIDTH-1:0]   dest_base,
    input  logic [I_ADDR_WIDTH-1:0]   length,
    output logic                      src_read_request,
    output logic [SRC_ADDR_WIDTH-1:0] src_read_address,
    input  logic [DATA_WIDTH-1:0]     src_read_data,
    input  logic                      src_read_valid,
    output logic                      flag_write_i_ram,
    output logic [I_ADDR_WIDTH-1:0]   i_ram_writing_address,
    output logic [DATA_WIDTH-1:0]     i_ram_input,
    output logic                      busy,
    output logic                      done,
    output logic                      error
`ifdef INSTRUCTION_RAM_LOADER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0]     checksum
`endif
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]         TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [I_ADDR_WIDTH:0] DEPTH     = (I_ADDR_WIDTH + 1)'(I_RAM_DEPTH);

    typedef enum logic [2:0] {IDLE, REQUEST, WAIT, WRITE, DONE} state_t;

    state_t                    state;
    logic [SRC_ADDR_WIDTH-1:0] src_base_q;
    logic [I_ADDR_WIDTH-1:0]   dest_base_q;
    logic [I_ADDR_WIDTH-1:0]   length_q;
    logic [I_ADDR_WIDTH-1:0]   count;
    logic [TW-1:0]             timer;

    logic [I_ADDR_WIDTH:0]     dest_end;
    logic                      range_bad;
    logic [I_ADDR_WIDTH-1:0]   count_next;

    // One extra bit so a destination range running past the RAM cannot wrap back in.
    assign dest_end   = {1'b0, dest_base} + {1'b0, length};
    assign range_bad  = (length == '0) || (dest_end > DEPTH);
    assign count_next = count + I_ADDR_WIDTH'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state                 <= IDLE;
            src_base_q            <= '0;
            dest_base_q           <= '0;
            length_q              <= '0;
            count                 <= '0;
            timer                 <= '0;
            src_read_request      <= 1'b0;
            src_read_address      <= '0;
            flag_write_i_ram      <= 1'b0;
            i_ram_writing_address <= '0;
            i_ram_input           <= '0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            error                 <= 1'b0;
`ifdef INSTRUCTION_RAM_LOADER_CHECKSUM_EN
            checksum              <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_base_q  <= src_base;
                        dest_base_q <= dest_base;
                        length_q    <= length;
                        count       <= '0;
                        busy        <= 1'b1;
                        error       <= 1'b0;
`ifdef INSTRUCTION_RAM_LOADER_CHECKSUM_EN
                        checksum    <= '0;
`endif
                        if (range_bad) begin
                            error <= 1'b1;
                            state <= DONE;
                        end else begin
                            src_read_request <= 1'b1;
                            src_read_address <= src_base;
                            state            <= REQUEST;
                        end
                    end
                end
                REQUEST: begin
                    src_read_request <= 1'b0;
                    timer            <= '0;
                    state            <= WAIT;
                end
                WAIT: begin
                    if (src_read_valid) begin
                        flag_write_i_ram      <= 1'b1;
                        i_ram_writing_address <= dest_base_q + count;
                        i_ram_input           <= src_read_data;
                        state                 <= WRITE;
                    end else if (timer == TIMER_LAST) begin
                        error <= 1'b1;
                        state <= DONE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                WRITE: begin
                    flag_write_i_ram <= 1'b0;
                    count            <= count_next;
`ifdef INSTRUCTION_RAM_LOADER_CHECKSUM_EN
                    checksum         <= checksum + i_ram_input;
`endif
                    if (count_next == length_q) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        src_read_request <= 1'b1;
                        src_read_address <= src_base_q + SRC_ADDR_WIDTH'(count_next);
                        state            <= REQUEST;
                    end
                end
                DONE: begin
                    // Aborts enter without the pulse and raise it here; a completed copy enters with it set.
                    if (done) begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_ram_loader.sv
// Directed and randomized loads against a timeline/arithmetic model of the loader.
module tb_instruction_ram_loader;

    localparam int TIMEOUT = 15;
    localparam int DEPTH   = 83;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] src_base;
    logic [9:0]  dest_base;
    logic [9:0]  length;
    logic        src_read_request;
    logic [15:0] src_read_address;
    logic [31:0] src_read_data = 32'h0;
    logic        src_read_valid = 1'b0;
    logic        flag_write_i_ram;
    logic [9:0]  i_ram_writing_address;
    logic [31:0] i_ram_input;
    logic        busy;
    logic        done;
    logic        error;
`ifdef INSTRUCTION_RAM_LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    always #5 clock = ~clock;

    instruction_ram_loader dut (
        .clock                 (clock),
        .reset                 (reset),
        .start                 (start),
        .src_base              (src_base),
        .dest_base             (dest_base),
        .length                (length),
        .src_read_request      (src_read_request),
        .src_read_address      (src_read_address),
        .src_read_data         (src_read_data),
        .src_read_valid        (src_read_valid),
        .flag_write_i_ram      (flag_write_i_ram),
        .i_ram_writing_address (i_ram_writing_address),
        .i_ram_input           (i_ram_input),
        .busy                  (busy),
        .done                  (done),
        .error                 (error)
`ifdef INSTRUCTION_RAM_LOADER_CHECKSUM_EN
        ,
        .checksum              (checksum)
`endif
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] src_mem [int];
    int          lat = 1;
    int          resp_limit = 0;
    int          served = 0;
    int          resp_cnt = 0;
    logic [15:0] pend_addr = 16'h0;

    int          n_writes, n_reads, done_rel, done_cnt;
    int          w_rel[$];
    logic [9:0]  w_addr[$];
    logic [31:0] w_dat[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Source memory: answers a limited number of requests, `lat` cycles after each one.
    always @(negedge clock) begin
        src_read_valid = 1'b0;
        if (reset) resp_cnt = 0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                src_read_valid = 1'b1;
                src_read_data  = src_mem.exists(int'(pend_addr)) ? src_mem[int'(pend_addr)] : 32'hDEAD_BEEF;
            end
        end
        if (src_read_request && served < resp_limit) begin
            served++;
            resp_cnt  = lat;
            pend_addr = src_read_address;
        end
    end

    function automatic logic [31:0] src_word(input logic [15:0] sb, input int i);
        logic [15:0] a;
        a = sb + 16'(i);
        return src_mem.exists(int'(a)) ? src_mem[int'(a)] : 32'hDEAD_BEEF;
    endfunction

    task automatic fill(input logic [15:0] sb, input int n);
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            a = sb + 16'(i);
            src_mem[int'(a)] = $urandom;
        end
    endtask

    // Issues one start and observes the run; rel counts cycles with the start cycle as 0.
    task automatic do_load(input logic [15:0] sb, input logic [9:0] db, input logic [9:0] len,
                           input int lt, input int resp, input int repulse_at, input int reset_after);
        int rel;
        int rst_rel;
        bit fin;
        lat        = lt;
        resp_limit = served + resp;
        n_writes = 0; n_reads = 0; done_rel = 0; done_cnt = 0;
        w_rel.delete(); w_addr.delete(); w_dat.delete();
        src_base = sb; dest_base = db; length = len; start = 1'b1;
        @(negedge clock);
        start   = 1'b0;
        rel     = 1;
        rst_rel = 0;
        fin     = 1'b0;
        while (!fin) begin
            if (flag_write_i_ram) begin
                n_writes++;
                w_rel.push_back(rel);
                w_addr.push_back(i_ram_writing_address);
                w_dat.push_back(i_ram_input);
            end
            if (src_read_request) n_reads++;
            if (done) begin
                if (done_cnt == 0) check("busy_at_done", busy, 1);
                done_cnt++;
                done_rel = rel;
            end
            if (rel == 1 && reset_after == 0) check("busy_after_start", busy, 1);
            if (repulse_at > 0 && rel == repulse_at) begin
                start = 1'b1; src_base = 16'hBEEF; dest_base = 10'd40; length = 10'd2;
            end
            if (repulse_at > 0 && rel == repulse_at + 1) start = 1'b0;
            if (rst_rel != 0 && rel == rst_rel + 1) begin
                reset = 1'b0;
                check("rst_ctrl", {src_read_request, flag_write_i_ram, busy, done, error}, 0);
                check("rst_addr", {src_read_address, i_ram_writing_address}, 0);
                check("rst_data", i_ram_input, 0);
`ifdef INSTRUCTION_RAM_LOADER_CHECKSUM_EN
                check("rst_sum", checksum, 0);
`endif
            end
            if (reset_after != 0 && rst_rel == 0 && n_writes == reset_after) begin
                reset   = 1'b1;
                rst_rel = rel;
            end
            if (done_cnt > 0 && rel == done_rel + 1) begin
                check("busy_after_done", busy, 0);
                check("done_one_cycle", done, 0);
                fin = 1'b1;
            end
            if (rst_rel != 0 && rel == rst_rel + 40) fin = 1'b1;
            if (rel >= 600) begin
                check("load_bound", done_cnt, 1);
                fin = 1'b1;
            end
            @(negedge clock);
            rel++;
        end
    endtask

    // Expected outcome from the load rules: range/length check, per-word 3+extra-latency cadence, timeout abort.
    task automatic verify(input string tag, input logic [15:0] sb, input logic [9:0] db,
                          input logic [9:0] len, input int lt, input int resp);
        bit          bad;
        int          nw;
        int          exp_reads;
        int          exp_done;
        logic [31:0] exp_sum;
        bad = (len == 0) || (int'(db) + int'(len) > DEPTH);
        nw  = bad ? 0 : ((resp < int'(len)) ? resp : int'(len));
        if (bad)                 exp_reads = 0;
        else if (nw == int'(len)) exp_reads = nw;
        else                     exp_reads = nw + 1;
        if (bad)                 exp_done = 2;
        else if (nw == int'(len)) exp_done = 2 + lt + (nw - 1) * (lt + 2) + 1;
        else                     exp_done = nw * (lt + 2) + TIMEOUT + 3;
        check({tag, "_writes"}, n_writes, nw);
        check({tag, "_reads"}, n_reads, exp_reads);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_done_cycle"}, done_rel, exp_done);
        check({tag, "_error"}, error, (bad || nw < int'(len)) ? 1 : 0);
        check({tag, "_busy_idle"}, busy, 0);
        exp_sum = 32'h0;
        for (int i = 0; i < nw && i < n_writes; i++) begin
            check({tag, "_wcycle"}, w_rel[i], 2 + lt + i * (lt + 2));
            check({tag, "_waddr"}, w_addr[i], db + 10'(i));
            check({tag, "_wdata"}, w_dat[i], src_word(sb, i));
            exp_sum += src_word(sb, i);
        end
`ifdef INSTRUCTION_RAM_LOADER_CHECKSUM_EN
        check({tag, "_checksum"}, checksum, exp_sum);
`endif
    endtask

    initial begin
        logic [15:0] sb;
        logic [9:0]  db;
        logic [9:0]  len;
        int          lt;
        reset = 1'b1; start = 1'b0; src_base = '0; dest_base = '0; length = '0;
        repeat (3) @(negedge clock);
        check("reset_ctrl", {src_read_request, flag_write_i_ram, busy, done, error}, 0);
        check("reset_addr", {src_read_address, i_ram_writing_address}, 0);
        check("reset_data", i_ram_input, 0);
        reset = 1'b0;
        @(negedge clock);

        src_mem[32'h100] = 32'h6C00_0000;
        src_mem[32'h101] = 32'h6800_0000;
        src_mem[32'h102] = 32'h76A0_0000;
        do_load(16'h0100, 10'd0, 10'd3, 1, 3, 0, 0);
        verify("basic", 16'h0100, 10'd0, 10'd3, 1, 3);
        check("basic_done_abs", done_rel, 10);
`ifdef INSTRUCTION_RAM_LOADER_CHECKSUM_EN
        check("basic_sum_abs", checksum, 32'h4AA0_0000);
`endif

        do_load(16'h0200, 10'd80, 10'd4, 1, 4, 0, 0);
        verify("range", 16'h0200, 10'd80, 10'd4, 1, 4);

        do_load(16'h0300, 10'd5, 10'd0, 1, 4, 0, 0);
        verify("zero_len", 16'h0300, 10'd5, 10'd0, 1, 4);

        fill(16'h0400, 3);
        do_load(16'h0400, 10'd80, 10'd3, 2, 3, 0, 0);
        verify("exact_fit", 16'h0400, 10'd80, 10'd3, 2, 3);

        fill(16'h0500, 2);
        do_load(16'h0500, 10'd10, 10'd2, 1, 1, 0, 0);
        verify("timeout", 16'h0500, 10'd10, 10'd2, 1, 1);

        fill(16'h0600, 3);
        do_load(16'h0600, 10'd20, 10'd3, 5, 3, 8, 0);
        verify("lat5_restart", 16'h0600, 10'd20, 10'd3, 5, 3);

        fill(16'hFFFE, 4);
        do_load(16'hFFFE, 10'd30, 10'd4, 1, 4, 0, 0);
        verify("src_wrap", 16'hFFFE, 10'd30, 10'd4, 1, 4);

        fill(16'h0700, 5);
        do_load(16'h0700, 10'd50, 10'd5, 1, 5, 0, 2);
        check("rstmid_writes", n_writes, 2);
        check("rstmid_no_done", done_cnt, 0);
        check("rstmid_addr1", w_addr[1], 10'd51);
        fill(16'h0800, 5);
        do_load(16'h0800, 10'd50, 10'd5, 1, 5, 0, 0);
        verify("after_reset", 16'h0800, 10'd50, 10'd5, 1, 5);

        for (int k = 0; k < 6; k++) begin
            sb  = 16'($urandom);
            db  = 10'($urandom_range(0, 82));
            len = 10'($urandom_range(0, 6));
            lt  = $urandom_range(1, 4);
            fill(sb, int'(len));
            do_load(sb, db, len, lt, int'(len), 0, 0);
            verify("random", sb, db, len, lt, int'(len));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instruction_ram_loader.md
Name: instruction_ram_loader

Overview:
- Writer-side master for the instruction RAM's write port (write flag, writing address, input word).
- Copies a block of program words from a word-addressed source memory (HD/data memory, request/valid read handshake) into consecutive instruction RAM locations.
- Raises done when the copy finishes, so the processor can be released to fetch from address 0 (or a chosen base) after a program load.

Parameters:
- DATA_WIDTH, 32, instruction word width.
- I_ADDR_WIDTH, 10, instruction RAM address width.
- SRC_ADDR_WIDTH, 16, source memory address width.
- I_RAM_DEPTH, 83, number of valid instruction RAM entries (0..I_RAM_DEPTH-1).
- TIMEOUT_CYCLES, 15, maximum WAIT cycles for src_read_valid before abort.

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle load request, sampled only in IDLE.
- src_base  in  SRC_ADDR_WIDTH  first source word address.
- dest_base  in  I_ADDR_WIDTH  first instruction RAM address.
- length  in  I_ADDR_WIDTH  number of words to copy.
- src_read_request  out  1  one-cycle read strobe.
- src_read_address  out  SRC_ADDR_WIDTH  read address, valid with the strobe.
- src_read_data  in  DATA_WIDTH  read data.
- src_read_valid  in  1  src_read_data valid this cycle.
- flag_write_i_ram  out  1  instruction RAM write enable.
- i_ram_writing_address  out  I_ADDR_WIDTH  write address.
- i_ram_input  out  DATA_WIDTH  write data.
- busy  out  1  high from the accepted start until the DONE state is left.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky abort flag, cleared by the next accepted start or by reset.

Behaviour:
- Reset (synchronous, active-high, takes priority in every state):
  - Next state IDLE.
  - All outputs 0; word counter 0; timer 0.
  - Reset mid-copy: no further writes; words already written remain in the RAM.
- States: IDLE, REQUEST, WAIT, WRITE, DONE. All outputs are registered.
- IDLE:
  - start=1 latches src_base, dest_base and length; clears error; sets busy=1.
  - If length==0, or dest_base+length > I_RAM_DEPTH (compare at I_ADDR_WIDTH+1 bits, no wrap): error=1, go to DONE, no reads or writes.
  - Otherwise go to REQUEST.
- REQUEST:
  - Drive src_read_request=1 for exactly one cycle, with src_read_address = src_base + count, truncated to SRC_ADDR_WIDTH (source address wraps).
  - Go to WAIT and clear the timer.
- WAIT:
  - src_read_valid is sampled only in this state; a valid asserted during REQUEST is ignored.
  - On valid: capture src_read_data and go to WRITE.
  - Otherwise increment the timer. When the timer equals TIMEOUT_CYCLES: error=1, go to DONE.
- WRITE:
  - For exactly one cycle: flag_write_i_ram=1, i_ram_writing_address = dest_base + count, i_ram_input = captured word.
  - Increment count. If the new count equals length, go to DONE; else go to REQUEST.
- DONE:
  - done=1 for one cycle; busy falls in the same cycle as the transition back to IDLE.
- Throughput: with valid arriving in the first WAIT cycle, each word takes 3 cycles (REQUEST, WAIT, WRITE).
  - N words: the first write is at cycle 3 after the start cycle; done follows the last write by 1 cycle.
- start while busy: ignored; no restart, no queuing.
- flag_write_i_ram is 0 in every state other than WRITE; address and data hold their last value when not writing.
- Source data is written unmodified. The loader never reads the instruction RAM.

Optional Feature:
- Macro: INSTRUCTION_RAM_LOADER_CHECKSUM_EN.
- Defined:
  - Adds output port checksum [DATA_WIDTH-1:0].
  - Cleared to 0 on reset and on each accepted start.
  - On every WRITE cycle the register becomes checksum + written word, modulo 2^DATA_WIDTH; the written word is the value driven on i_ram_input that cycle.
  - Valid (stable) when done pulses; holds until the next start.
  - An aborted load leaves the partial sum.
- Undefined: the port and the adder do not exist; all other behaviour is identical.

Test Plan:
- Basic copy:
  - Stimulus: src_base=0x0100, dest_base=0, length=3; source returns 0x6C000000, 0x68000000, 0x76A00000 with valid one cycle after each request.
  - Required: writes to addresses 0, 1, 2 on cycles 3, 6, 9 after start; done on cycle 10; error=0; checksum (if enabled) = 0x4AA00000.
- Range check:
  - Stimulus: dest_base=80, length=4 (84 > 83).
  - Required: no src_read_request, no writes; error=1; done pulses 2 cycles after start.
- Zero length:
  - Stimulus: length=0.
  - Required: error=1, done, zero reads and zero writes.
- Timeout:
  - Stimulus: length=2; valid never returned for the second request.
  - Required: exactly one write; error=1 after 15 WAIT cycles, then done.
- Variable latency and ignored start:
  - Stimulus: valid returned 5 cycles after each request; start re-pulsed mid-copy.
  - Required: writes are spaced 7 cycles apart; the second start has no effect.
- Reset mid-copy:
  - Stimulus: assert reset for one cycle after the second write of a length-5 load.
  - Required: all outputs 0 on the next cycle; no third write; a new start then performs a complete load.
